// File: rtl/systolic_array_driver.sv
// Systolic array driver: holds operand matrices A and B, streams them into
// an N_SIZE x N_SIZE systolic array (A by columns, B by rows), then collects
// the result matrix C row by row from the array and exposes it through a
// registered read port. A watchdog flags an array that never answers, and a
// row stream that stops early is also reported as an error.
module systolic_array_driver #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_en,
  input  logic                           load_sel,
  input  logic [$clog2(N_SIZE)-1:0]      load_row,
  input  logic [$clog2(N_SIZE)-1:0]      load_col,
  input  logic signed [DATAWIDTH-1:0]    load_data,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           sa_valid_in,
  output logic signed [DATAWIDTH-1:0]    sa_a_out [0:N_SIZE-1],
  output logic signed [DATAWIDTH-1:0]    sa_b_out [0:N_SIZE-1],
  input  logic                           sa_valid_out,
  input  logic [2*DATAWIDTH-1:0]         sa_matrix_in [0:N_SIZE-1],
  input  logic [$clog2(N_SIZE)-1:0]      rd_row,
  input  logic [$clog2(N_SIZE)-1:0]      rd_col,
  output logic [2*DATAWIDTH-1:0]         rd_data
);

  localparam int IW = $clog2(N_SIZE);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_SIZE - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  state_t state;

  logic signed [DATAWIDTH-1:0]   a_mem  [N_SIZE][N_SIZE];
  logic signed [DATAWIDTH-1:0]   b_mem  [N_SIZE][N_SIZE];
  logic [2*DATAWIDTH-1:0]        c_mem  [N_SIZE][N_SIZE];
  logic signed [DATAWIDTH-1:0]   a_view [N_SIZE][N_SIZE];
  logic signed [DATAWIDTH-1:0]   b_view [N_SIZE][N_SIZE];

  logic [IW-1:0] k;
  logic [IW-1:0] k_next;
  logic [IW-1:0] r;
  logic [CW-1:0] wait_cnt;
  logic          load_ok;
  logic          load_write;
  logic          rd_ok;

  // Operand writes are only honoured while idle and with in-range indices.
  always_comb begin
    load_ok    = (int'(load_row) < N_SIZE) && (int'(load_col) < N_SIZE);
    load_write = (state == IDLE) && load_en && load_ok;
    rd_ok      = (int'(rd_row) < N_SIZE) && (int'(rd_col) < N_SIZE);
    k_next     = k + IW'(1);
  end

  // Operand view including a same-cycle write, so a load issued together
  // with start is already seen by the first feed column.
  always_comb begin
    for (int i = 0; i < N_SIZE; i++) begin
      for (int j = 0; j < N_SIZE; j++) begin
        a_view[i][j] = a_mem[i][j];
        b_view[i][j] = b_mem[i][j];
      end
    end
    if (load_write) begin
      if (!load_sel) a_view[load_row][load_col] = load_data;
      else           b_view[load_row][load_col] = load_data;
    end
  end

  // Operand storage for A and B, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SIZE; i++) begin
        for (int j = 0; j < N_SIZE; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
    end else if (load_write) begin
      if (!load_sel) a_mem[load_row][load_col] <= load_data;
      else           b_mem[load_row][load_col] <= load_data;
    end
  end

  // Main controller: feed sequencing, response capture, watchdog and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      sa_valid_in <= 1'b0;
      k           <= '0;
      r           <= '0;
      wait_cnt    <= '0;
      for (int i = 0; i < N_SIZE; i++) begin
        sa_a_out[i] <= '0;
        sa_b_out[i] <= '0;
        for (int j = 0; j < N_SIZE; j++) begin
          c_mem[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= FEED;
            busy        <= 1'b1;
            error       <= 1'b0;
            k           <= '0;
            wait_cnt    <= '0;
            r           <= '0;
            sa_valid_in <= 1'b1;
            for (int i = 0; i < N_SIZE; i++) begin
              sa_a_out[i] <= a_view[i][0];
              sa_b_out[i] <= b_view[0][i];
            end
          end
        end

        FEED: begin
          if (k == LAST_IDX) begin
            state       <= WAIT;
            sa_valid_in <= 1'b0;
            wait_cnt    <= '0;
            for (int i = 0; i < N_SIZE; i++) begin
              sa_a_out[i] <= '0;
              sa_b_out[i] <= '0;
            end
          end else begin
            k <= k_next;
            for (int i = 0; i < N_SIZE; i++) begin
              sa_a_out[i] <= a_mem[i][k_next];
              sa_b_out[i] <= b_mem[k_next][i];
            end
          end
        end

        WAIT: begin
          if (sa_valid_out) begin
            for (int c = 0; c < N_SIZE; c++) begin
              c_mem[0][c] <= sa_matrix_in[c];
            end
            r     <= IW'(1);
            state <= CAPTURE;
          end else if (wait_cnt == WAIT_LAST) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        CAPTURE: begin
          if (sa_valid_out) begin
            for (int c = 0; c < N_SIZE; c++) begin
              c_mem[r][c] <= sa_matrix_in[c];
            end
            if (r == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              r <= r + IW'(1);
            end
          end else begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          k        <= '0;
          r        <= '0;
          wait_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          sa_valid_in <= 1'b0;
        end
      endcase
    end
  end

  // Registered result read port, usable in any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_data <= c_mem[rd_row][rd_col];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_systolic_array_driver.sv
// Directed bench for systolic_array_driver: plays the role of the host
// (loads, start, reads) and of the systolic array (row responses).
module tb_systolic_array_driver;

  localparam int DW = 16;
  localparam int N  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 load_en;
  logic                 load_sel;
  logic [1:0]           load_row;
  logic [1:0]           load_col;
  logic signed [DW-1:0] load_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 sa_valid_in;
  logic signed [DW-1:0] sa_a_out [0:N-1];
  logic signed [DW-1:0] sa_b_out [0:N-1];
  logic                 sa_valid_out;
  logic [2*DW-1:0]      sa_matrix_in [0:N-1];
  logic [1:0]           rd_row;
  logic [1:0]           rd_col;
  logic [2*DW-1:0]      rd_data;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic             valid;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
  } feed_vec_t;

  typedef struct packed {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] exp;
  } rd_vec_t;

  feed_vec_t   feed_tab [4];
  rd_vec_t     rd_tab   [9];
  logic [31:0] resp_rows [3][3];

  systolic_array_driver #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_sel     (load_sel),
    .load_row     (load_row),
    .load_col     (load_col),
    .load_data    (load_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .sa_valid_in  (sa_valid_in),
    .sa_a_out     (sa_a_out),
    .sa_b_out     (sa_b_out),
    .sa_valid_out (sa_valid_out),
    .sa_matrix_in (sa_matrix_in),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  function automatic feed_vec_t mk_feed(input logic v, input int a0, a1, a2, b0, b1, b2);
    feed_vec_t f;
    f.valid = v;
    f.a[0] = 16'(a0); f.a[1] = 16'(a1); f.a[2] = 16'(a2);
    f.b[0] = 16'(b0); f.b[1] = 16'(b1); f.b[2] = 16'(b2);
    return f;
  endfunction

  function automatic rd_vec_t mk_rd(input int row, input int col, input logic [31:0] exp);
    rd_vec_t v;
    v.row = 2'(row);
    v.col = 2'(col);
    v.exp = exp;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle operand write (caller sits at a negedge).
  task automatic applyStimulus(input logic sel, input int row, input int col, input int data);
    load_en   = 1'b1;
    load_sel  = sel;
    load_row  = 2'(row);
    load_col  = 2'(col);
    load_data = 16'(data);
    step();
    load_en   = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic readCheck(input string name, input int row, input int col, input logic [31:0] exp);
    rd_row = 2'(row);
    rd_col = 2'(col);
    step();
    checkOutput(name, 64'(rd_data), 64'(exp));
  endtask

  // Array model: wait for the feed to end, return all rows, wait for done.
  task automatic respond();
    int n;
    n = 0;
    while (sa_valid_in && n < 20) begin step(); n++; end
    if (n >= 20) checkOutput("respond_feed_end", 64'(sa_valid_in), 64'd0);
    for (int rr = 0; rr < N; rr++) begin
      sa_valid_out = 1'b1;
      for (int c = 0; c < N; c++) sa_matrix_in[c] = resp_rows[rr][c];
      step();
    end
    sa_valid_out = 1'b0;
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    checkOutput("respond_done", 64'(done), 64'd1);
    step();
  endtask

  initial begin
    int n;
    int a_init [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int b_init [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};

    feed_tab[0] = mk_feed(1'b1, 1, 4, 7, 9, 8, 7);
    feed_tab[1] = mk_feed(1'b1, 2, 5, 8, 6, 5, 4);
    feed_tab[2] = mk_feed(1'b1, 3, 6, 9, 3, 2, 1);
    feed_tab[3] = mk_feed(1'b0, 0, 0, 0, 0, 0, 0);

    resp_rows[0] = '{32'd30,  32'd24,  32'd18};
    resp_rows[1] = '{32'd84,  32'd69,  32'd54};
    resp_rows[2] = '{32'd138, 32'd114, 32'd90};

    for (int i = 0; i < 9; i++) rd_tab[i] = mk_rd(i / 3, i % 3, resp_rows[i / 3][i % 3]);

    rst_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
    load_data = '0; start = 1'b0; sa_valid_out = 1'b0; rd_row = '0; rd_col = '0;
    for (int c = 0; c < N; c++) sa_matrix_in[c] = '0;

    // Reset state
    repeat (2) step();
    checkOutput("rst_busy",  64'(busy), 64'd0);
    checkOutput("rst_done",  64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_valid", 64'(sa_valid_in), 64'd0);
    checkOutput("rst_rd",    64'(rd_data), 64'd0);
    checkOutput("rst_a0",    64'(sa_a_out[0]), 64'd0);
    rst_n = 1'b1;
    step();

    // Nominal multiply
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, i / 3, i % 3, a_init[i]);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, i / 3, i % 3, b_init[i]);
    pulseStart();
    checkOutput("run_busy", 64'(busy), 64'd1);
    for (int e = 0; e < 4; e++) begin
      checkOutput($sformatf("feed%0d_valid", e), 64'(sa_valid_in), 64'(feed_tab[e].valid));
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("feed%0d_a%0d", e, i), 64'(sa_a_out[i]), 64'(feed_tab[e].a[i]));
        checkOutput($sformatf("feed%0d_b%0d", e, i), 64'(sa_b_out[i]), 64'(feed_tab[e].b[i]));
      end
      if (e < 3) step();
    end
    repeat (3) step();
    for (int rr = 0; rr < N; rr++) begin
      checkOutput($sformatf("wait_done_low%0d", rr), 64'(done), 64'd0);
      sa_valid_out = 1'b1;
      for (int c = 0; c < N; c++) sa_matrix_in[c] = resp_rows[rr][c];
      step();
    end
    sa_valid_out = 1'b0;
    checkOutput("run_done",  64'(done), 64'd1);
    checkOutput("run_error", 64'(error), 64'd0);
    checkOutput("run_busy_at_done", 64'(busy), 64'd1);
    step();
    checkOutput("idle_done", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 9; i++)
      readCheck($sformatf("c%0d%0d", rd_tab[i].row, rd_tab[i].col), int'(rd_tab[i].row), int'(rd_tab[i].col), rd_tab[i].exp);

    // Watchdog: no response at all
    pulseStart();
    repeat (3) step();
    n = 0;
    while (!done && n < 200) begin step(); n++; end
    checkOutput("timeout_cycles", 64'(n), 64'd64);
    checkOutput("timeout_error", 64'(error), 64'd1);
    step();
    checkOutput("timeout_error_held", 64'(error), 64'd1);
    checkOutput("timeout_busy_idle", 64'(busy), 64'd0);

    // Row stream stops after two rows
    pulseStart();
    repeat (3) step();
    sa_valid_out = 1'b1;
    for (int c = 0; c < N; c++) sa_matrix_in[c] = resp_rows[0][c];
    step();
    sa_matrix_in[0] = 32'd84;
    sa_matrix_in[1] = 32'd69;
    sa_matrix_in[2] = 32'hFFFF_FFCA;
    step();
    sa_valid_out = 1'b0;
    step();
    checkOutput("partial_done",  64'(done), 64'd1);
    checkOutput("partial_error", 64'(error), 64'd1);
    step();
    readCheck("partial_c00", 0, 0, 32'd30);
    readCheck("partial_c11", 1, 1, 32'd69);
    readCheck("partial_c12_wide", 1, 2, 32'hFFFF_FFCA);

    // Reset in the middle of the feed
    pulseStart();
    step();
    checkOutput("feed1_before_rst", 64'(sa_valid_in), 64'd1);
    rst_n = 1'b0;
    step();
    checkOutput("midrst_valid", 64'(sa_valid_in), 64'd0);
    checkOutput("midrst_busy",  64'(busy), 64'd0);
    checkOutput("midrst_a0",    64'(sa_a_out[0]), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      readCheck($sformatf("midrst_c%0d", i), i / 3, i % 3, 32'd0);

    // Loads and starts while busy are ignored
    applyStimulus(1'b0, 0, 0, 1);
    pulseStart();
    load_en = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0; load_data = 16'sd5;
    start = 1'b1;
    step();
    load_en = 1'b0;
    start = 1'b0;
    respond();
    checkOutput("busy_start_ignored", 64'(busy), 64'd0);
    pulseStart();
    checkOutput("busy_load_ignored_a0", 64'(sa_a_out[0]), 64'd1);
    respond();

    // Load together with start reaches the first feed column
    load_en = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0; load_data = -16'sd2;
    start = 1'b1;
    step();
    load_en = 1'b0;
    start = 1'b0;
    checkOutput("same_cycle_valid", 64'(sa_valid_in), 64'd1);
    checkOutput("same_cycle_a0", 64'(sa_a_out[0]), 64'(-2));
    respond();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/systolic_array_driver.md
SYSTOLIC_ARRAY_DRIVER -- requirements
Module: systolic_array_driver

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, signed operand width.
REQ-002 SHALL have parameter N_SIZE, default 3, square matrix dimension (N_SIZE >= 2).
REQ-003 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before error.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 load_en  in  1  write one operand element.
REQ-007 load_sel  in  1  0 = matrix A, 1 = matrix B.
REQ-008 load_row, load_col  in  $clog2(N_SIZE) each  element index.
REQ-009 load_data  in  DATAWIDTH signed  element value.
REQ-010 start  in  1  begin a multiply.
REQ-011 busy  out  1  high from the cycle after accepted start through the done cycle.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 error  out  1  status of last run; valid with done, held until next accepted start.
REQ-014 sa_valid_in  out  1  drives array valid_in.
REQ-015 sa_a_out  out  [0:N_SIZE-1] x DATAWIDTH signed  A column stream.
REQ-016 sa_b_out  out  [0:N_SIZE-1] x DATAWIDTH signed  B row stream.
REQ-017 sa_valid_out  in  1  array valid_out.
REQ-018 sa_matrix_in  in  [0:N_SIZE-1] x 2*DATAWIDTH  one C row per valid cycle.
REQ-019 rd_row, rd_col  in  $clog2(N_SIZE) each; rd_data  out  2*DATAWIDTH  result read, registered, 1-cycle latency.

Function
REQ-020 FSM states SHALL be IDLE, FEED, WAIT, CAPTURE, DONE.
REQ-021 In IDLE, load_en SHALL write load_data to A[row][col] or B[row][col]; out-of-range indices ignored; load_en outside IDLE ignored.
REQ-022 start in IDLE SHALL move to FEED next cycle, clear k and error; start outside IDLE ignored.
REQ-023 load_en and start in the same IDLE cycle: write SHALL take effect and be visible to the feed.
REQ-024 FEED: sa_valid_in SHALL be high exactly N_SIZE consecutive cycles; in cycle k, sa_a_out[i] = A[i][k], sa_b_out[j] = B[k][j]; after k = N_SIZE-1, go WAIT.
REQ-025 Outside FEED, sa_valid_in, sa_a_out, sa_b_out SHALL be 0.
REQ-026 WAIT: cycle counter SHALL increment each cycle; on sa_valid_out = 1 capture sa_matrix_in as C row 0 that cycle, go CAPTURE with r = 1.
REQ-027 WAIT reaching TIMEOUT cycles without sa_valid_out SHALL set error = 1, go DONE.
REQ-028 CAPTURE: each cycle with sa_valid_out = 1 SHALL store sa_matrix_in[c] to C[r][c], r++; after row N_SIZE-1 is stored, go DONE.
REQ-029 sa_valid_out = 0 in CAPTURE before all rows are captured SHALL set error = 1, go DONE; partial rows retained.
REQ-030 DONE SHALL assert done for one cycle, then IDLE; busy low from that IDLE cycle.
REQ-031 sa_valid_out in IDLE, FEED or DONE SHALL be ignored.
REQ-032 Stored C values SHALL be taken unmodified (no truncation or sign change); rd_data reflects C one cycle after rd_row/rd_col and is readable in any state.

Reset
REQ-033 rst_n low at a clock edge SHALL force IDLE and set busy, done, error, sa_valid_in, rd_data to 0, sa_a_out and sa_b_out to 0, counters to 0, and clear A, B and C storage to 0, including mid-FEED/WAIT/CAPTURE.

Verification
REQ-034 Load A = [1 2 3;4 5 6;7 8 9], B = [9 8 7;6 5 4;3 2 1], start -> sa_valid_in high 3 cycles; a_out {1,4,7},{2,5,8},{3,6,9}; b_out {9,8,7},{6,5,4},{3,2,1}.
REQ-035 Responder returns rows {30,24,18},{84,69,54},{138,114,90} 4 cycles after feed -> done pulse, error = 0; reads C[1][2] = 54 and C[2][0] = 138.
REQ-036 No sa_valid_out after feed -> done with error = 1 exactly 64 cycles after entering WAIT.
REQ-037 sa_valid_out drops after 2 rows -> done, error = 1; C[0][0] = 30, C[1][1] = 69.
REQ-038 rst_n low during FEED cycle 1 -> next edge sa_valid_in = 0, busy = 0; all C reads 0.
REQ-039 start and load_en (A[0][0] = 5) while busy -> ignored; next run feeds A[0][0] = 1; load of -2 with start in the same IDLE cycle -> sa_a_out[0] = -2 in feed cycle 0.
